// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, branch resolve, divider, EX/MEM register
// Optional M extension (MUL/DIV/REM) enabled by defining M_EXT_EN.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rs1_num_in,
  input  logic [4:0]  rs2_num_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        alu_src_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_in,
  input  logic [3:0]  alu_op_in,
  input  logic [2:0]  bru_op_in,
  input  logic [2:0]  ls_op_in,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic        exmem_reg_write,
  input  logic        memwb_reg_write,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic        busy,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [2:0]  ls_op_out
);

  logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_out, result;
  logic [4:0]  shamt;
  logic        cond, is_jump;

  // The younger producer (EX/MEM) wins; x0 is never forwarded.
  always_comb begin
    rs1_fwd = rs1_data_in;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs1_num_in)
      rs1_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1_num_in)
      rs1_fwd = memwb_result;
    rs2_fwd = rs2_data_in;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs2_num_in)
      rs2_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2_num_in)
      rs2_fwd = memwb_result;
  end

  assign op_a  = rs1_fwd;
  assign op_b  = alu_src_in ? imm_in : rs2_fwd;
  assign shamt = op_b[4:0];

`ifdef M_EXT_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      quo, rem, divisor, dividend, div_result;
  logic [31:0]      a_mag, b_mag, quo_nxt, rem_nxt;
  logic [32:0]      shifted, diff;
  logic             is_div_op, sgn, a_neg, b_neg, neg_q, neg_r, is_rem, div_zero, ge;

  assign is_div_op = (alu_op_in[3:2] == 2'b11);
  assign sgn       = ~alu_op_in[0];
  assign a_neg     = sgn & op_a[31];
  assign b_neg     = sgn & op_b[31];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, divisor};
  assign ge      = ~diff[32];
  assign rem_nxt = ge ? diff[31:0] : shifted[31:0];
  assign quo_nxt = {quo[30:0], ge};

  assign busy = (state == IDLE && is_div_op) || (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      dividend   <= '0;
      div_result <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_rem     <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_div_op) begin
          quo      <= a_mag;
          rem      <= '0;
          divisor  <= b_mag;
          dividend <= op_a;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          is_rem   <= alu_op_in[1];
          div_zero <= (op_b == 32'd0);
          cnt      <= '0;
          state    <= RUN;
        end
        RUN: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
            // Divide by zero bypasses the sign fixup so the quotient stays all ones.
            if (div_zero)
              div_result <= is_rem ? dividend : 32'hFFFF_FFFF;
            else if (is_rem)
              div_result <= neg_r ? -rem_nxt : rem_nxt;
            else
              div_result <= neg_q ? -quo_nxt : quo_nxt;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    alu_out = 32'd0;
    case (alu_op_in)
      4'd0:  alu_out = op_a + op_b;
      4'd1:  alu_out = op_a - op_b;
      4'd2:  alu_out = op_a << shamt;
      4'd3:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_out = {31'd0, op_a < op_b};
      4'd5:  alu_out = op_a ^ op_b;
      4'd6:  alu_out = op_a >> shamt;
      4'd7:  alu_out = 32'($signed(op_a) >>> shamt);
      4'd8:  alu_out = op_a | op_b;
      4'd9:  alu_out = op_a & op_b;
      4'd10: alu_out = op_b;
`ifdef M_EXT_EN
      4'd11: alu_out = op_a * op_b;
      4'd12, 4'd13, 4'd14, 4'd15: alu_out = (state == DONE) ? div_result : 32'd0;
`endif
      default: alu_out = 32'd0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (bru_op_in)
      3'd0: cond = (rs1_fwd == rs2_fwd);
      3'd1: cond = (rs1_fwd != rs2_fwd);
      3'd2, 3'd3: cond = 1'b1;
      3'd4: cond = $signed(rs1_fwd) < $signed(rs2_fwd);
      3'd5: cond = $signed(rs1_fwd) >= $signed(rs2_fwd);
      3'd6: cond = rs1_fwd < rs2_fwd;
      3'd7: cond = rs1_fwd >= rs2_fwd;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken  = branch_in & cond;
  assign is_jump       = branch_in && (bru_op_in == 3'd2 || bru_op_in == 3'd3);
  assign branch_target = (branch_in && bru_op_in == 3'd3) ? ((rs1_fwd + imm_in) & ~32'd1)
                                                          : (pc_in + imm_in);
  assign result        = is_jump ? (pc_in + 32'd4) : alu_out;

  // While stalled the memory stage sees a bubble; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      ls_op_out      <= '0;
    end else if (busy) begin
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else begin
      alu_result_out <= result;
      store_data_out <= rs2_fwd;
      rd_out         <= rd_in;
      reg_write_out  <= reg_write_in;
      mem_to_reg_out <= mem_to_reg_in;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      ls_op_out      <= ls_op_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - table-driven bench for ex_stage plus divider and reset sequences
module tb_ex_stage;

`ifdef M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
  logic [4:0]  rs1_num_in, rs2_num_in, rd_in;
  logic        reg_write_in, alu_src_in, mem_to_reg_in, mem_read_in, mem_write_in, branch_in;
  logic [3:0]  alu_op_in;
  logic [2:0]  bru_op_in, ls_op_in;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        busy, branch_taken;
  logic [31:0] branch_target, alu_result_out, store_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out;
  logic [2:0]  ls_op_out;

  int total = 0;
  int passed = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .rs1_num_in(rs1_num_in), .rs2_num_in(rs2_num_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .alu_src_in(alu_src_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .branch_in(branch_in),
    .alu_op_in(alu_op_in), .bru_op_in(bru_op_in), .ls_op_in(ls_op_in),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_reg_write(memwb_reg_write), .exmem_result(exmem_result), .memwb_result(memwb_result),
    .busy(busy), .branch_taken(branch_taken), .branch_target(branch_target),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .ls_op_out(ls_op_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        src;
    logic        br;
    logic [2:0]  bru;
    logic [31:0] a, b, imm, pc, res;
    logic        tk;
    logic [31:0] tgt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, logic [3:0] op, logic src, logic br, logic [2:0] bru,
                              logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [31:0] pc,
                              logic [31:0] res, logic tk, logic [31:0] tgt);
    vec_t v;
    v.name = n; v.op = op; v.src = src; v.br = br; v.bru = bru;
    v.a = a; v.b = b; v.imm = imm; v.pc = pc; v.res = res; v.tk = tk; v.tgt = tgt;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic drive(input logic [3:0] op, input logic src, input logic br, input logic [2:0] bru,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc);
    alu_op_in = op; alu_src_in = src; branch_in = br; bru_op_in = bru;
    rs1_data_in = a; rs2_data_in = b; imm_in = imm; pc_in = pc;
    rs1_num_in = 5'd1; rs2_num_in = 5'd2;
    exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'd0;
    memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'd0;
  endtask

  task automatic nop();
    drive(4'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    rd_in = 5'd0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; ls_op_in = 3'd0;
  endtask

  task automatic check_cleared(input string n);
    check({n, " result"}, alu_result_out, 32'd0);
    check({n, " store"}, store_data_out, 32'd0);
    check({n, " ctrl"}, {27'd0, rd_out, reg_write_out, mem_to_reg_out, mem_read_out,
                         mem_write_out, ls_op_out} >> 0, 32'd0);
    check({n, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Starts at posedge+1; returns at posedge+1 after the result has been captured.
  task automatic run_div(input string n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int nb;
    logic bad;
    logic [31:0] prev;
    drive(op, 1'b0, 1'b0, 3'd0, a, b, 32'd0, 32'd0);
    rd_in = 5'd9; reg_write_in = 1'b1;
    prev = alu_result_out;
    nb = 0;
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!busy) break;
      nb++;
      @(posedge clk); #1;
      if (reg_write_out !== 1'b0 || alu_result_out !== prev) bad = 1'b1;
    end
    check({n, " busy cycles"}, nb, M_EN ? 32'd33 : 32'd0);
    check({n, " bubble"}, {31'd0, bad}, 32'd0);
    @(posedge clk); #1;
    check({n, " result"}, alu_result_out, M_EN ? exp : 32'd0);
    check({n, " reg_write"}, {31'd0, reg_write_out}, 32'd1);
    nop();
  endtask

  initial begin
    nop();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    vq.push_back(mk("add",   4'd0,  0, 0, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12, 0, 32'd0));
    vq.push_back(mk("sub",   4'd1,  0, 0, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE, 0, 32'd0));
    vq.push_back(mk("sll",   4'd2,  1, 0, 3'd0, 32'd1, 32'hDEAD, 32'h24, 32'd0, 32'h10, 0, 32'd0));
    vq.push_back(mk("slt",   4'd3,  0, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 0, 32'd0));
    vq.push_back(mk("sltu",  4'd4,  0, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 0, 32'd0));
    vq.push_back(mk("xor",   4'd5,  0, 0, 3'd0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 32'h0FF0, 0, 32'd0));
    vq.push_back(mk("srl",   4'd6,  0, 0, 3'd0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'h0800_0000, 0, 32'd0));
    vq.push_back(mk("sra",   4'd7,  0, 0, 3'd0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'hF800_0000, 0, 32'd0));
    vq.push_back(mk("or",    4'd8,  0, 0, 3'd0, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'hFF, 0, 32'd0));
    vq.push_back(mk("and",   4'd9,  0, 0, 3'd0, 32'hF0, 32'h3C, 32'd0, 32'd0, 32'h30, 0, 32'd0));
    vq.push_back(mk("passb", 4'd10, 1, 0, 3'd0, 32'd3, 32'd4, 32'h1234_5000, 32'd0, 32'h1234_5000, 0, 32'd0));
    vq.push_back(mk("beq",   4'd0,  0, 1, 3'd0, 32'd3, 32'd3, 32'h20, 32'h100, 32'd6, 1, 32'h120));
    vq.push_back(mk("bne",   4'd0,  0, 1, 3'd1, 32'd3, 32'd3, 32'h20, 32'h100, 32'd6, 0, 32'h120));
    vq.push_back(mk("jalr",  4'd0,  1, 1, 3'd3, 32'h1001, 32'd0, 32'd4, 32'h40, 32'h44, 1, 32'h1004));
    vq.push_back(mk("jal",   4'd0,  1, 1, 3'd2, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h200, 32'h204, 1, 32'h1F8));
    vq.push_back(mk("blt",   4'd0,  0, 1, 3'd4, 32'hFFFF_FFFB, 32'd3, 32'h10, 32'h0, 32'hFFFF_FFFE, 1, 32'h10));
    vq.push_back(mk("bge",   4'd0,  0, 1, 3'd5, 32'd3, 32'd3, 32'h10, 32'h8, 32'd6, 1, 32'h18));
    vq.push_back(mk("bltu",  4'd0,  0, 1, 3'd6, 32'hFFFF_FFFB, 32'd3, 32'h10, 32'h0, 32'hFFFF_FFFE, 0, 32'h10));
    vq.push_back(mk("bgeu",  4'd0,  0, 1, 3'd7, 32'd2, 32'd3, 32'h10, 32'h0, 32'd5, 0, 32'h10));
    vq.push_back(mk("mul",   4'd11, 0, 0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0,
                    M_EN ? 32'hFFFF_FFEB : 32'd0, 0, 32'd0));

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op, vq[i].src, vq[i].br, vq[i].bru, vq[i].a, vq[i].b, vq[i].imm, vq[i].pc);
      rd_in = 5'(i + 1); reg_write_in = 1'b1; ls_op_in = 3'(i);
      mem_to_reg_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
      #2;
      check({vq[i].name, " taken"}, {31'd0, branch_taken}, {31'd0, vq[i].tk});
      if (vq[i].br) check({vq[i].name, " target"}, branch_target, vq[i].tgt);
      @(posedge clk); #1;
      check({vq[i].name, " result"}, alu_result_out, vq[i].res);
      check({vq[i].name, " store"}, store_data_out, vq[i].b);
      check({vq[i].name, " rd/ls"}, {24'd0, rd_out, ls_op_out}, {24'd0, 5'(i + 1), 3'(i)});
    end

    // Forwarding priority and x0 suppression
    drive(4'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    rs1_num_in = 5'd5; rs2_num_in = 5'd0; rd_in = 5'd6; reg_write_in = 1'b1;
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h11;
    memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h22;
    @(posedge clk); #1;
    check("fwd exmem wins", alu_result_out, 32'h11);
    exmem_reg_write = 1'b0;
    @(posedge clk); #1;
    check("fwd memwb", alu_result_out, 32'h22);
    rs1_num_in = 5'd0; rs2_num_in = 5'd5;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h99;
    memwb_reg_write = 1'b0; rs2_data_in = 32'h7;
    @(posedge clk); #1;
    check("fwd x0 blocked", alu_result_out, 32'h7);
    exmem_rd = 5'd5; exmem_result = 32'h33;
    @(posedge clk); #1;
    check("fwd store data", store_data_out, 32'h33);
    nop();
    @(posedge clk); #1;

    run_div("divu 100/7", 4'd13, 32'd100, 32'd7, 32'd14);
    run_div("remu 100/7", 4'd15, 32'd100, 32'd7, 32'd2);
    run_div("div -7/2",   4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("rem -7/2",   4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("div ovf",    4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("rem ovf",    4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_div("divu 5/0",   4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_div("remu 5/0",   4'd15, 32'd5, 32'd0, 32'd5);
    run_div("div -7/0",   4'd12, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_div("rem -7/0",   4'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // Reset in the middle of a division discards it
    drive(4'd13, 1'b0, 1'b0, 3'd0, 32'd100, 32'd7, 32'd0, 32'd0);
    rd_in = 5'd9; reg_write_in = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    nop();
    #2;
    check_cleared("mid-div reset");
    @(posedge clk); #1;
    rst = 1'b0;
    run_div("divu after reset", 4'd13, 32'd100, 32'd7, 32'd14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
